// File: rtl/fp_sub.sv
// Multi-cycle IEEE-754 single-precision subtractor (DIFF = A - B, round-to-nearest-even).
// Start/done handshake; result and flags are registered and held until the next done.
module fp_sub (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [31:0] DIFF,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_PACK
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] a_reg, b_reg;
  logic        sign_reg, eff_sub_reg;
  logic [9:0]  exp_reg;
  logic [26:0] l_ext_reg, s_ext_reg;
  logic [27:0] m_reg;
  logic [31:0] res_reg, diff_reg;
  logic        ovf_reg, unf_reg, inv_reg;
  logic        done_reg, ovf_out_reg, unf_out_reg, inv_out_reg;

  // Operand classification for the special-case shortcut
  logic [7:0]  a_exp, b_exp;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special_hit;
  logic [31:0] sp_res;
  logic        sp_inv;

  assign a_exp       = a_reg[30:23];
  assign b_exp       = b_reg[30:23];
  assign a_zero      = (a_exp == 8'h00);
  assign b_zero      = (b_exp == 8'h00);
  assign a_inf       = (a_exp == 8'hFF) && (a_reg[22:0] == 23'h0);
  assign b_inf       = (b_exp == 8'hFF) && (b_reg[22:0] == 23'h0);
  assign a_nan       = (a_exp == 8'hFF) && (a_reg[22:0] != 23'h0);
  assign b_nan       = (b_exp == 8'hFF) && (b_reg[22:0] != 23'h0);
  assign special_hit = (a_exp == 8'hFF) || (b_exp == 8'hFF) || a_zero || b_zero;

  always_comb begin
    sp_res = 32'h0000_0000;
    sp_inv = 1'b0;
    if (a_nan || b_nan) begin
      sp_res = 32'h7FC0_0000;
      sp_inv = 1'b1;
    end else if (a_inf && b_inf && (a_reg[31] == b_reg[31])) begin
      sp_res = 32'h7FC0_0000;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_res = a_reg;
    end else if (b_inf) begin
      sp_res = {~b_reg[31], 8'hFF, 23'h0};
    end else if (a_zero && b_zero) begin
      sp_res = {a_reg[31] & ~b_reg[31], 31'h0};
    end else if (b_zero) begin
      sp_res = a_reg;
    end else if (a_zero) begin
      sp_res = {~b_reg[31], b_reg[30:0]};
    end
  end

  // Alignment: larger magnitude is L, smaller is shifted right with sticky collection
  logic        a_ge;
  logic [30:0] big_mag, small_mag;
  logic [7:0]  shamt;
  logic [26:0] small_ext, shifted, lost_bits, s_aligned;
  logic        sticky;

  assign a_ge      = (a_reg[30:0] >= b_reg[30:0]);
  assign big_mag   = a_ge ? a_reg[30:0] : b_reg[30:0];
  assign small_mag = a_ge ? b_reg[30:0] : a_reg[30:0];
  assign shamt     = big_mag[30:23] - small_mag[30:23];
  assign small_ext = {1'b1, small_mag[22:0], 3'b000};
  assign shifted   = small_ext >> shamt;

  genvar gi;
  generate
    for (gi = 0; gi < 27; gi++) begin : g_lost
      assign lost_bits[gi] = (shamt > 8'(gi)) & small_ext[gi];
    end
  endgenerate

  assign sticky    = |lost_bits;
  assign s_aligned = (shamt >= 8'd27) ? 27'd1 : {shifted[26:1], shifted[0] | sticky};

  logic [27:0] sum;
  logic        sum_zero, norm_uflow;
  assign sum        = eff_sub_reg ? ({1'b0, l_ext_reg} - {1'b0, s_ext_reg})
                                  : ({1'b0, l_ext_reg} + {1'b0, s_ext_reg});
  assign sum_zero   = (sum == 28'h0);
  assign norm_uflow = !m_reg[27] && !m_reg[26] && (exp_reg == 10'd1);

  // Rounding: G/R/S are the three bits below the 24-bit mantissa
  logic [23:0] mant, rnd_mant;
  logic [24:0] mant_inc;
  logic [9:0]  rnd_exp;
  logic        round_up, rnd_ovf;
  assign mant     = m_reg[26:3];
  assign round_up = m_reg[2] & (m_reg[1] | m_reg[0] | mant[0]);
  assign mant_inc = {1'b0, mant} + {24'h0, round_up};
  assign rnd_mant = mant_inc[24] ? mant_inc[24:1] : mant_inc[23:0];
  assign rnd_exp  = exp_reg + {9'h0, mant_inc[24]};
  assign rnd_ovf  = (rnd_exp >= 10'd255);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (sub) state_next = S_UNPACK;
      S_UNPACK: state_next = special_hit ? S_PACK : S_ALIGN;
      S_ALIGN:  state_next = S_ADDSUB;
      S_ADDSUB: state_next = sum_zero ? S_PACK : S_NORM;
      S_NORM: begin
        if (m_reg[27] || m_reg[26]) state_next = S_ROUND;
        else if (norm_uflow)        state_next = S_PACK;
      end
      S_ROUND:  state_next = S_PACK;
      S_PACK:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg <= '0; b_reg <= '0; sign_reg <= 1'b0; eff_sub_reg <= 1'b0;
      exp_reg <= '0; l_ext_reg <= '0; s_ext_reg <= '0; m_reg <= '0;
      res_reg <= '0; ovf_reg <= 1'b0; unf_reg <= 1'b0; inv_reg <= 1'b0;
      diff_reg <= '0; done_reg <= 1'b0;
      ovf_out_reg <= 1'b0; unf_out_reg <= 1'b0; inv_out_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: if (sub) begin
          a_reg <= A; b_reg <= B;
          ovf_reg <= 1'b0; unf_reg <= 1'b0; inv_reg <= 1'b0;
        end
        S_UNPACK: if (special_hit) begin
          res_reg <= sp_res;
          inv_reg <= sp_inv;
        end
        S_ALIGN: begin
          sign_reg    <= a_ge ? a_reg[31] : ~b_reg[31];
          eff_sub_reg <= (a_reg[31] == b_reg[31]);
          exp_reg     <= {2'b00, big_mag[30:23]};
          l_ext_reg   <= {1'b1, big_mag[22:0], 3'b000};
          s_ext_reg   <= s_aligned;
        end
        S_ADDSUB: begin
          m_reg <= sum;
          if (sum_zero) res_reg <= 32'h0000_0000;
        end
        S_NORM: begin
          if (m_reg[27]) begin
            m_reg   <= {1'b0, m_reg[27:2], m_reg[1] | m_reg[0]};
            exp_reg <= exp_reg + 10'd1;
          end else if (!m_reg[26]) begin
            if (norm_uflow) begin
              res_reg <= {sign_reg, 31'h0};
              unf_reg <= 1'b1;
            end else begin
              m_reg   <= {m_reg[26:0], 1'b0};
              exp_reg <= exp_reg - 10'd1;
            end
          end
        end
        S_ROUND: begin
          res_reg <= rnd_ovf ? {sign_reg, 8'hFF, 23'h0}
                             : {sign_reg, rnd_exp[7:0], rnd_mant[22:0]};
          ovf_reg <= rnd_ovf;
        end
        S_PACK: begin
          diff_reg    <= res_reg;
          ovf_out_reg <= ovf_reg;
          unf_out_reg <= unf_reg;
          inv_out_reg <= inv_reg;
          done_reg    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_reg;
  assign DIFF      = diff_reg;
  assign overflow  = ovf_out_reg;
  assign underflow = unf_out_reg;
  assign invalid   = inv_out_reg;
endmodule

// File: tb/tb_fp_sub.sv
// Scoreboard bench for fp_sub: the driver queues expected results, a monitor checks each done.
module tb_fp_sub;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sub = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] DIFF;

  fp_sub dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .sub(sub),
    .busy(busy), .done(done), .DIFF(DIFF),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] F_OVF = 3'b100, F_UNF = 3'b010, F_INV = 3'b001;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Accept-edge log used for latency measurement
  always @(posedge clock) begin
    cyc_cnt <= cyc_cnt + 1;
    if (reset) acc_q.delete();
    else if (sub && !busy) acc_q.push_back(cyc_cnt + 1);
  end

  always @(negedge clock) begin
    exp_t e;
    int   lat;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: DIFF=%h with no pending operation", DIFF);
      end else begin
        e   = exp_q.pop_front();
        lat = (acc_q.size() != 0) ? cyc_cnt - acc_q.pop_front() : -1;
        $display("op %h - %h : DIFF=%h flags(o,u,i)=%b latency=%0d", e.a, e.b, DIFF,
                 {overflow, underflow, invalid}, lat);
        check("diff", DIFF, e.diff);
        check("flags", {29'h0, overflow, underflow, invalid}, {29'h0, e.flags});
        check("latency", lat, e.lat);
      end
    end
  end

  // Issue one operation from an idle negedge; returns on the negedge where done is high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic [2:0] f, input int lat);
    A = a; B = b; sub = 1'b1;
    exp_q.push_back('{a, b, d, f, lat});
    @(posedge clock);
    @(negedge clock);
    sub = 1'b0;
    A = $urandom; B = $urandom;
    for (int i = 0; i < 200 && !done; i++) @(negedge clock);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for %h - %h, got busy=%b expected done", a, b, busy);
      exp_q.delete();
    end
  endtask

  logic [31:0] bb_a[4] = '{32'h40400000, 32'h3F800000, 32'h40A00000, 32'h7F800000};
  logic [31:0] bb_b[4] = '{32'h3F800000, 32'hBF800000, 32'h40A00000, 32'h7F800000};
  logic [31:0] bb_d[4] = '{32'h40000000, 32'h40000000, 32'h00000000, 32'h7FC00000};
  logic [2:0]  bb_f[4] = '{3'b000, 3'b000, 3'b000, 3'b001};
  int          bb_l[4] = '{6, 6, 4, 2};

  initial begin
    int nb, run, max_run;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_diff", DIFF, 32'h0);
    check("rst_flags", {29'h0, overflow, underflow, invalid}, 32'h0);
    reset = 1'b0;

    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 6);
    run_op(32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 3'b000, 30);
    run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 3'b000, 6);
    run_op(32'h40A00000, 32'h40A00000, 32'h00000000, 3'b000, 4);
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, F_OVF, 6);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, F_INV, 2);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_INV, 2);
    run_op(32'h7F800000, 32'hFF800000, 32'h7F800000, 3'b000, 2);
    run_op(32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000, 2);
    run_op(32'h40200000, 32'h00000000, 32'h40200000, 3'b000, 2);
    run_op(32'h00000000, 32'h40200000, 32'hC0200000, 3'b000, 2);
    run_op(32'h80000000, 32'h00000000, 32'h80000000, 3'b000, 2);
    run_op(32'h00000000, 32'h80000000, 32'h00000000, 3'b000, 2);
    run_op(32'h00000001, 32'h00000000, 32'h00000000, 3'b000, 2);
    run_op(32'h3F800000, 32'h40400000, 32'hC0000000, 3'b000, 6);
    run_op(32'h3F800000, 32'h33000000, 32'h3F800000, 3'b000, 7);
    run_op(32'h3F800000, 32'hB3800000, 32'h3F800000, 3'b000, 6);
    run_op(32'h3F800000, 32'hB3C00000, 32'h3F800001, 3'b000, 6);
    run_op(32'h80800001, 32'h80800000, 32'h80000000, F_UNF, 5);

    repeat (3) @(negedge clock);
    check("diff_hold", DIFF, 32'h80000000);

    // Abort a long operation with a one-cycle reset
    A = 32'h3F800000; B = 32'h3F7FFFFF; sub = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sub = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_diff", DIFF, 32'h0);
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 6);

    // Back-to-back with sub held high and operands scrambled while busy
    nb = 0; run = 0; max_run = 0;
    for (int i = 0; i < 400 && (nb < 4 || busy); i++) begin
      if (!busy) begin
        if (nb > 0) begin
          run++;
          if (run > max_run) max_run = run;
        end
        A = bb_a[nb]; B = bb_b[nb]; sub = 1'b1;
        exp_q.push_back('{bb_a[nb], bb_b[nb], bb_d[nb], bb_f[nb], bb_l[nb]});
        nb++;
      end else begin
        run = 0;
        A = $urandom; B = $urandom;
      end
      @(negedge clock);
    end
    sub = 1'b0;
    check("b2b_finished", {31'h0, busy}, 32'h0);
    check("b2b_idle_gap", max_run, 1);

    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_sub.md
# fp_sub

Multi-cycle IEEE-754 single-precision subtractor computing DIFF = A − B with round-to-nearest-even. It complements the existing floating-point adder in the arithmetic datapath and uses the same start/done style handshake. It carries its own alignment, normalization, rounding and special-case logic; it is not an adder with B's sign flipped. Its result and flags are registered and held until the next operation completes.

## Interface
- No parameters.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- A  in  32  minuend, IEEE-754 single; sampled only on the accepting edge.
- B  in  32  subtrahend, IEEE-754 single; sampled only on the accepting edge.
- sub  in  1  start request; level-sensitive; accepted only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when DIFF and the flags are valid.
- DIFF  out  32  result; holds until the next done.
- overflow  out  1  result rounded to ±Inf; updated with DIFF.
- underflow  out  1  result flushed to signed zero; updated with DIFF.
- invalid  out  1  result is the canonical NaN; updated with DIFF.

## Operation
- **Reset:** state=IDLE, DIFF=0, done=0, busy=0, all flags 0. Reset in any state aborts the operation; no done is produced.
- **Accept:** on an edge with state=IDLE and sub=1, A and B are registered and the FSM moves to UNPACK. sub is ignored while busy. sub held high restarts an operation immediately after each done.
- **FSM:** IDLE → UNPACK → ALIGN → ADDSUB → NORM (1..N cycles) → ROUND → PACK → IDLE.
- **Special-case shortcuts:** UNPACK → PACK for special inputs. ADDSUB → PACK for an exact-zero difference.
- **UNPACK:**
  - Exponent 0 (zero or denormal) → treated as zero of the same sign.
  - Exponent 255 → Inf or NaN.
  - Normal operand significand = {1, frac} (24 bits).
- **Specials, resolved in UNPACK:**
  - Any NaN → 0x7FC00000, invalid=1.
  - Inf − Inf with equal signs → 0x7FC00000, invalid=1.
  - Inf − x → A.
  - x − Inf → Inf with sign ~B[31].
  - A − 0 → A.
  - 0 − B → B with sign flipped.
  - 0 − 0 → −0 only for (−0) − (+0); otherwise +0.
- **ALIGN:**
  - Compare {exp, frac} magnitudes; the larger becomes operand L.
  - Result sign = A[31] if |A| ≥ |B|, else ~B[31].
  - Effective operation = magnitude subtract if sign(A) = sign(B), else magnitude add.
  - Smaller operand is extended to 27 bits (24 + G, R, S) and shifted right by the exponent difference in one cycle.
  - Shifted-out bits are ORed into S. A difference ≥ 27 leaves only S set.
- **ADDSUB:**
  - 28-bit result (carry + 27).
  - Zero magnitude → +0, go to PACK.
- **NORM:**
  - Carry set: one right shift, S keeps the OR of shifted-out bits, exp+1, done in one cycle.
  - Otherwise one left shift and exp−1 per cycle until bit 23 is 1. At most 26 shifts.
  - exp reaching 0 → signed zero, underflow=1, go to PACK.
- **ROUND:**
  - Round-to-nearest-even: increment when G & (R | S | lsb).
  - Mantissa carry-out → shift right, exp+1.
  - exp ≥ 255 → ±Inf (0x7F800000 | sign), overflow=1.
- **PACK:** on exit, DIFF ← {sign, exp[7:0], frac[22:0]}, flags ← computed values, done ← 1, state ← IDLE.

## Timing
- Edge E0 accepts. done is high during the cycle after edge E(L).
- Normal path: L = 6 + k, where k = number of left-normalization shifts.
- Carry path: L = 6.
- Special inputs: L = 2.
- Exact-zero difference: L = 4.
- done is high for exactly one cycle. busy falls on the same edge that raises done.
- DIFF and the flags change only on the edge that raises done.
- A/B changes after E0 do not affect the result.
- Back-to-back: sub=1 during the done cycle is accepted on the next edge.

## Test plan
- 0x40400000 (3.0) − 0x3F800000 (1.0) → DIFF=0x40000000, done 6 cycles after accept, flags 0.
- 0x3F800000 − 0x3F7FFFFF → DIFF=0x33800000 (2^-24), 24 left shifts, done at cycle 30.
- 0x3F800000 − 0xBF800000 (1 − (−1)) → 0x40000000 via carry path, latency 6. Also 0x40A00000 − 0x40A00000 → 0x00000000, latency 4.
- 0x7F7FFFFF − 0xFF7FFFFF → 0x7F800000, overflow=1. Then 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1, latency 2.
- Assert reset for one cycle at cycle 3 of an operation → no done, busy=0 and DIFF=0 next cycle. A new sub is accepted on the following edge and completes normally.
- Hold sub=1 with A/B changed every cycle → each result matches the operands present on its accepting edge. Accepts occur on the edge after each done; busy never drops for more than one cycle.
